dmem_arbiter32: RTL and testbench

- Two-requester arbiter and sequencer in front of the 32-bit byte-addressed, big-endian data memory.
- Port A is the core load/store unit. Port B is the program loader / debug DMA.
- Grants one access at a time with round-robin fairness, drives the memory's write-enable, address, data and mode inputs, and returns registered read data plus an ack/error pulse.
- Screens illegal, misaligned and out-of-range accesses so the memory never sees them.

---
 rtl/dmem_arbiter32.sv | 198 +++++++++++++++++++
 tb/tb_dmem_arbiter32.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter32.sv
// Two-port round-robin arbiter in front of the big-endian data memory.
// One access at a time: IDLE -> ACCESS (memory driven) -> DONE (ack/err pulse).
module dmem_arbiter32 #(
    parameter int N         = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_req,
    input  logic         a_we,
    input  logic [N-1:0] a_addr,
    input  logic [N-1:0] a_wdata,
    input  logic [2:0]   a_mode,
    output logic         a_gnt,
    output logic         a_ack,
    output logic         a_err,
    output logic [N-1:0] a_rdata,
    input  logic         b_req,
    input  logic         b_we,
    input  logic [N-1:0] b_addr,
    input  logic [N-1:0] b_wdata,
    input  logic [2:0]   b_mode,
    output logic         b_gnt,
    output logic         b_ack,
    output logic         b_err,
    output logic [N-1:0] b_rdata,
    output logic         mem_write_enable,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_write_data,
    output logic [2:0]   mem_mode,
    input  logic [N-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       PORT_A    = 1'b0;
    localparam logic [N:0] MEM_LIMIT = (N+1)'(MEM_BYTES);

    state_t         state_reg, state_next;
    logic           prio_reg, prio_next;

    logic           req_port_reg;
    logic           req_we_reg;
    logic [N-1:0]   req_addr_reg;
    logic [N-1:0]   req_wdata_reg;
    logic [2:0]     req_mode_reg;

    logic           grant_valid;
    logic           grant_port;
    logic           bad;
    logic [2:0]     size_m1;
    logic [N:0]     last_byte;

    // Port inputs gathered into arrays indexed by port number (0 = A, 1 = B)
    logic [1:0]     p_req;
    logic [1:0]     p_we;
    logic [N-1:0]   p_addr  [2];
    logic [N-1:0]   p_wdata [2];
    logic [2:0]     p_mode  [2];

    logic [1:0]     gnt_reg, gnt_next;
    logic [1:0]     ack_reg, ack_next;
    logic [1:0]     err_reg, err_next;
    logic [N-1:0]   rdata_reg  [2];
    logic [N-1:0]   rdata_next [2];

    assign p_req      = {b_req, a_req};
    assign p_we       = {b_we, a_we};
    assign p_addr[0]  = a_addr;
    assign p_addr[1]  = b_addr;
    assign p_wdata[0] = a_wdata;
    assign p_wdata[1] = b_wdata;
    assign p_mode[0]  = a_mode;
    assign p_mode[1]  = b_mode;

    // Screening of the latched request; the memory never sees a bad access
    always_comb begin
        size_m1 = 3'd0;
        bad     = 1'b0;
        case (req_mode_reg[1:0])
            2'b00: size_m1 = 3'd0;
            2'b01: begin
                size_m1 = 3'd1;
                bad     = req_addr_reg[0];
            end
            2'b10: begin
                size_m1 = 3'd3;
                bad     = |req_addr_reg[1:0];
            end
            default: bad = 1'b1;
        endcase
        last_byte = {1'b0, req_addr_reg} + (N+1)'(size_m1);
        if (last_byte >= MEM_LIMIT) begin
            bad = 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_valid = 1'b0;
        grant_port  = PORT_A;
        case (state_reg)
            IDLE: begin
                if (&p_req) begin
                    grant_valid = 1'b1;
                    grant_port  = prio_reg;
                end else if (p_req[0]) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b0;
                end else if (p_req[1]) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b1;
                end
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = DONE;
            DONE: begin
                // The port just acked is not eligible this cycle
                grant_port  = ~req_port_reg;
                grant_valid = p_req[grant_port];
                state_next  = grant_valid ? ACCESS : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign prio_next = (state_reg == ACCESS) ? ~req_port_reg : prio_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);
            logic is_winner_access;

            assign is_winner_access = (state_reg == ACCESS) && (req_port_reg == PORT_ID);
            assign gnt_next[gi]     = grant_valid && (grant_port == PORT_ID);
            assign ack_next[gi]     = is_winner_access;
            assign err_next[gi]     = is_winner_access && bad;
            // Stores leave the port's load data untouched
            assign rdata_next[gi]   = (is_winner_access && !req_we_reg)
                                      ? (bad ? '0 : mem_read_data)
                                      : rdata_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            prio_reg      <= PORT_A;
            req_port_reg  <= PORT_A;
            req_we_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            req_mode_reg  <= '0;
            gnt_reg       <= '0;
            ack_reg       <= '0;
            err_reg       <= '0;
            rdata_reg[0]  <= '0;
            rdata_reg[1]  <= '0;
        end else begin
            state_reg    <= state_next;
            prio_reg     <= prio_next;
            gnt_reg      <= gnt_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            rdata_reg[0] <= rdata_next[0];
            rdata_reg[1] <= rdata_next[1];
            if (grant_valid) begin
                req_port_reg  <= grant_port;
                req_we_reg    <= p_we[grant_port];
                req_addr_reg  <= p_addr[grant_port];
                req_wdata_reg <= p_wdata[grant_port];
                req_mode_reg  <= p_mode[grant_port];
            end
        end
    end

    // Memory side comes from the latched request, so it holds between accesses
    assign mem_write_enable = (state_reg == ACCESS) && req_we_reg && !bad;
    assign mem_addr         = req_addr_reg;
    assign mem_write_data   = req_wdata_reg;
    assign mem_mode         = req_mode_reg;

    assign a_gnt   = gnt_reg[0];
    assign b_gnt   = gnt_reg[1];
    assign a_ack   = ack_reg[0];
    assign b_ack   = ack_reg[1];
    assign a_err   = err_reg[0];
    assign b_err   = err_reg[1];
    assign a_rdata = rdata_reg[0];
    assign b_rdata = rdata_reg[1];

endmodule

// File: tb/tb_dmem_arbiter32.sv
// Directed bench for dmem_arbiter32 with a big-endian byte memory model.
module tb_dmem_arbiter32;

    logic        clk;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [2:0]  a_mode, b_mode;
    logic        a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_write_enable;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [2:0]  mem_mode;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;

    logic [7:0] mem [0:1023] = '{default: 8'h00};

    dmem_arbiter32 #(.N(32), .MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mode(a_mode),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mode(b_mode),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_mode(mem_mode),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd8(input logic [31:0] a);
        return (a < 32'd1024) ? mem[a[9:0]] : 8'h00;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] mode);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd8(a);
        h = {rd8(a), rd8(a + 32'd1)};
        case (mode[1:0])
            2'b00:   return mode[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return mode[2] ? {16'h0, h} : {{16{h[15]}}, h};
            2'b10:   return {rd8(a), rd8(a + 32'd1), rd8(a + 32'd2), rd8(a + 32'd3)};
            default: return 32'h0;
        endcase
    endfunction

    always_comb mem_read_data = mem_rd(mem_addr, mem_mode);

    always @(posedge clk) begin
        if (mem_write_enable && mem_addr < 32'd1024) begin
            wr_cnt <= wr_cnt + 1;
            case (mem_mode[1:0])
                2'b00: mem[mem_addr[9:0]] <= mem_write_data[7:0];
                2'b01: begin
                    mem[mem_addr[9:0]]         <= mem_write_data[15:8];
                    mem[mem_addr[9:0] + 10'd1] <= mem_write_data[7:0];
                end
                2'b10: begin
                    mem[mem_addr[9:0]]         <= mem_write_data[31:24];
                    mem[mem_addr[9:0] + 10'd1] <= mem_write_data[23:16];
                    mem[mem_addr[9:0] + 10'd2] <= mem_write_data[15:8];
                    mem[mem_addr[9:0] + 10'd3] <= mem_write_data[7:0];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // One complete access on a port; addr switches to alt_addr once ACCESS starts
    task automatic access(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] alt_addr, input logic [31:0] wdata,
                          input logic [2:0] mode, output logic err, output logic [31:0] rdata,
                          output int lat, output logic gnt_seen, output int wr_delta);
        int w0;
        w0 = wr_cnt;
        if (!port) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_mode = mode;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_mode = mode;
        end
        lat = 0;
        gnt_seen = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                gnt_seen = port ? b_gnt : a_gnt;
                if (!port) a_addr = alt_addr; else b_addr = alt_addr;
            end
        end while (!(port ? b_ack : a_ack) && lat < 20);
        err   = port ? b_err : a_err;
        rdata = port ? b_rdata : a_rdata;
        if (!port) a_req = 1'b0; else b_req = 1'b0;
        @(posedge clk); #1;
        wr_delta = wr_cnt - w0;
        $display("access port=%0d we=%0d addr=%h mode=%b lat=%0d err=%0d rdata=%h writes=%0d",
                 port, we, addr, mode, lat, err, rdata, wr_delta);
    endtask

    logic        t_err, t_gnt;
    logic [31:0] t_rdata;
    int          t_lat, t_wr, w_before;
    logic        ack_seen;
    logic [1:0]  exp_gnt_tbl [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [1:0]  exp_ack_tbl [8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    initial begin
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_mode = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({a_gnt, b_gnt, a_ack, b_ack, a_err, b_err, mem_write_enable}), 32'h0);
        check("rst_a_rdata", a_rdata, 32'h0);
        check("rst_b_rdata", b_rdata, 32'h0);
        check("rst_mem_bus", mem_addr | mem_write_data | 32'(mem_mode), 32'h0);
        rst = 1'b0;

        // Word store then load back
        access(1'b0, 1'b1, 32'h10, 32'h10, 32'hDEADBEEF, 3'b010, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("st_latency", 32'(t_lat), 32'd2);
        check("st_gnt", 32'(t_gnt), 32'd1);
        check("st_err", 32'(t_err), 32'd0);
        check("st_writes", 32'(t_wr), 32'd1);
        check("st_mem", mem_rd(32'h10, 3'b010), 32'hDEADBEEF);
        check("ack_pulse", 32'({a_ack, a_err}), 32'd0);
        access(1'b0, 1'b0, 32'h10, 32'h10, 32'h0, 3'b010, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("ld_word", t_rdata, 32'hDEADBEEF);
        check("ld_writes", 32'(t_wr), 32'd0);

        // Byte store, signed and unsigned byte loads
        access(1'b0, 1'b1, 32'h20, 32'h20, 32'h00000080, 3'b000, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("stb_err", 32'(t_err), 32'd0);
        access(1'b0, 1'b0, 32'h20, 32'h20, 32'h0, 3'b000, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("ldb_signed", t_rdata, 32'hFFFFFF80);
        access(1'b0, 1'b0, 32'h20, 32'h20, 32'h0, 3'b100, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("ldb_unsigned", t_rdata, 32'h00000080);
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", a_rdata, 32'h00000080);

        // Screened accesses
        access(1'b0, 1'b1, 32'h22, 32'h22, 32'h12345678, 3'b010, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("misalign_err", 32'(t_err), 32'd1);
        check("misalign_wr", 32'(t_wr), 32'd0);
        check("misalign_mem", mem_rd(32'h20, 3'b010), 32'h80000000);
        access(1'b0, 1'b0, 32'h10, 32'h10, 32'h0, 3'b011, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("mode11_err", 32'(t_err), 32'd1);
        check("mode11_rdata", t_rdata, 32'h0);
        access(1'b0, 1'b0, 32'h3FE, 32'h3FE, 32'h0, 3'b010, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("range_err", 32'(t_err), 32'd1);
        access(1'b0, 1'b0, 32'h3FC, 32'h3FC, 32'h0, 3'b010, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("range_edge_ok", 32'(t_err), 32'd0);
        access(1'b0, 1'b0, 32'h21, 32'h21, 32'h0, 3'b001, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("half_mis_err", 32'(t_err), 32'd1);
        access(1'b1, 1'b1, 32'h3FE, 32'h3FE, 32'h0000ABCD, 3'b001, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("half_top_err", 32'(t_err), 32'd0);
        check("half_top_wr", 32'(t_wr), 32'd1);
        access(1'b1, 1'b0, 32'h3FE, 32'h3FE, 32'h0, 3'b101, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("half_top_ld", t_rdata, 32'h0000ABCD);

        // Contention straight out of reset: A, B, A, B
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_mode = 3'b010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20; b_mode = 3'b010;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("rr_gnt_c%0d", k + 1), 32'({a_gnt, b_gnt}), 32'(exp_gnt_tbl[k]));
            check($sformatf("rr_ack_c%0d", k + 1), 32'({a_ack, b_ack}), 32'(exp_ack_tbl[k]));
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;
        check("rr_a_rdata", a_rdata, 32'hDEADBEEF);
        check("rr_b_rdata", b_rdata, 32'h80000000);

        // Live address change during ACCESS must not matter
        access(1'b1, 1'b0, 32'h10, 32'h40, 32'h0, 3'b010, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("latched_addr", t_rdata, 32'hDEADBEEF);
        check("latched_err", 32'(t_err), 32'd0);

        // A completes last so the pointer favours B before the aborted store
        access(1'b0, 1'b0, 32'h10, 32'h10, 32'h0, 3'b010, t_err, t_rdata, t_lat, t_gnt, t_wr);
        check("pre_abort_ld", t_rdata, 32'hDEADBEEF);

        w_before = wr_cnt;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'hCAFEF00D; a_mode = 3'b010;
        @(posedge clk); #1;
        check("abort_gnt", 32'(a_gnt), 32'd1);
        rst = 1'b1;
        a_req = 1'b0;
        #1;
        check("abort_we_low", 32'(mem_write_enable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ack_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (a_ack) ack_seen = 1'b1;
        end
        check("abort_no_ack", 32'(ack_seen), 32'd0);
        check("abort_no_wr", 32'(wr_cnt - w_before), 32'd0);
        check("abort_mem", mem_rd(32'h30, 3'b010), 32'h0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_mode = 3'b010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20; b_mode = 3'b010;
        @(posedge clk); #1;
        check("abort_prio_a", 32'({a_gnt, b_gnt}), 32'(2'b10));
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
